window_generator: RTL and testbench

- Producer side of the 3x3 window interface consumed by the smoothening stage (9 taps x LANES, 8-bit pixels).
- Accepts a raster-order pixel stream, LANES parallel independent channels per beat, and buffers two prior rows per lane.
- Emits one complete 3x3 neighbourhood per accepted interior pixel, with a valid/ready handshake on both sides.

---
 rtl/img_pkg.sv | 20 ++
 rtl/window_generator_line_buffer.sv | 25 ++
 rtl/window_generator.sv | 121 ++++++++++++
 tb/tb_window_generator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline types and the 3x3 tap-index mapping used by the
// window producer (window_generator) and the smoothening consumer.
package img_pkg;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned WIN_TAPS = 9;

   typedef logic [PIX_W-1:0]          pixel_t;
   typedef pixel_t [WIN_TAPS-1:0]     win_t;

   // Tap j = 3*dr + dc; dr/dc count from the top-left (oldest row/column).
   localparam int unsigned TAP_ROW_STRIDE = 3;
   localparam int unsigned TAP_CENTRE     = 4;
   localparam int unsigned TAP_NEWEST     = 8;

   function automatic int unsigned tap_idx(input int unsigned dr, input int unsigned dc);
      return TAP_ROW_STRIDE * dr + dc;
   endfunction

endpackage

// File: rtl/window_generator_line_buffer.sv
// Single-lane, single-row pixel delay addressed by column; dout is the value
// stored one row earlier at addr (read happens before the write).
module line_buffer
   import img_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned DEPTH = 640,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

endmodule

// File: rtl/window_generator.sv
// Raster stream to 3x3 neighbourhood generator, LANES independent channels.
// Optional macro WINGEN_COORD_EN adds centre-pixel coordinates out_x/out_y.
module window_generator
   import img_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned PIX_W = 8,
   parameter int unsigned LANES = 2
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [LANES-1:0][PIX_W-1:0]             in_pix,
   input  logic                                    in_sof,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   output logic [LANES-1:0][WIN_TAPS-1:0][PIX_W-1:0] window,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    out_sof,
   output logic                                    out_eol
`ifdef WINGEN_COORD_EN
   ,
   output logic [$clog2(IMG_W)-1:0]                out_x,
   output logic [$clog2(IMG_H)-1:0]                out_y
`endif
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col, pos_c;
   logic [RW-1:0] row, pos_r;
   logic          accept, emit;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // An accepted start-of-frame overrides the running position for this beat.
   assign pos_c    = in_sof ? '0 : col;
   assign pos_r    = in_sof ? '0 : row;
   assign emit     = accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (pos_c == COL_LAST) begin
            col <= '0;
            row <= (pos_r == ROW_LAST) ? '0 : pos_r + RW'(1);
         end else begin
            col <= pos_c + CW'(1);
            row <= pos_r;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
`ifdef WINGEN_COORD_EN
         out_x     <= '0;
         out_y     <= '0;
`endif
      end else if (emit) begin
         out_valid <= 1'b1;
         out_sof   <= (pos_r == RW'(2)) && (pos_c == CW'(2));
         out_eol   <= (pos_c == COL_LAST);
`ifdef WINGEN_COORD_EN
         out_x     <= pos_c - CW'(1);
         out_y     <= pos_r - RW'(1);
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [PIX_W-1:0]                up1, up2;
      logic [WIN_TAPS-1:0][PIX_W-1:0] win_sr, hist, sr_next, win_q;

      line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_row1 (
         .clk  (clk),
         .we   (accept),
         .addr (pos_c),
         .din  (in_pix[l]),
         .dout (up1)
      );

      line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_row2 (
         .clk  (clk),
         .we   (accept),
         .addr (pos_c),
         .din  (up1),
         .dout (up2)
      );

      // Shift one column left; column history is dropped at the start of a row.
      always_comb begin
         hist    = (pos_c == '0) ? '0 : win_sr;
         sr_next = {in_pix[l], hist[8:7], up1, hist[5:4], up2, hist[2:1]};
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            win_sr <= '0;
            win_q  <= '0;
         end else begin
            if (accept) win_sr <= sr_next;
            if (emit)   win_q  <= sr_next;
         end
      end

      assign window[l] = win_q;
   end

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator at IMG_W=5, IMG_H=4, LANES=2.
module tb_window_generator;

   localparam int unsigned W  = 5;
   localparam int unsigned H  = 4;
   localparam int unsigned PW = 8;
   localparam int unsigned L  = 2;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [L-1:0][PW-1:0]       in_pix;
   logic                       in_sof, in_valid, in_ready;
   logic [L-1:0][8:0][PW-1:0]  window;
   logic                       out_valid, out_ready, out_sof, out_eol;
`ifdef WINGEN_COORD_EN
   logic [2:0]                 out_x;
   logic [1:0]                 out_y;
`endif

   always #5 clk = ~clk;

   window_generator #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .LANES(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_pix    (in_pix),
      .in_sof    (in_sof),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .window    (window),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sof   (out_sof),
      .out_eol   (out_eol)
`ifdef WINGEN_COORD_EN
      ,
      .out_x     (out_x),
      .out_y     (out_y)
`endif
   );

   typedef struct {
      logic [L-1:0][8:0][PW-1:0] win;
      logic                      sof;
      logic                      eol;
      int                        x;
      int                        y;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   mr = 0, mc = 0;
   int   dut_wins = 0, dut_eols = 0;
   bit   want_first = 1'b0;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [PW-1:0] pix(input int lane, input int r, input int c);
      return PW'(lane * 100 + 5 * r + c);
   endfunction

   function automatic logic [71:0] lane_win(input int lane, input int r, input int c);
      logic [71:0] w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w = {pix(lane, r - 2 + dr, c - 2 + dc), w[71:8]};
      return w;
   endfunction

   function automatic exp_t mk(input int r, input int c);
      exp_t e;
      e.win = {lane_win(1, r, c), lane_win(0, r, c)};
      e.sof = (r == 2 && c == 2);
      e.eol = (c == W - 1);
      e.x   = c - 1;
      e.y   = r - 1;
      return e;
   endfunction

   task automatic check_out();
      logic [71:0] t;
      int          s;
      chk("out_valid", 160'(out_valid), 160'(q.size() != 0));
      if (q.size() != 0) begin
         chk("window", 160'(window), 160'(q[0].win));
         chk("out_sof", 160'(out_sof), 160'(q[0].sof));
         chk("out_eol", 160'(out_eol), 160'(q[0].eol));
`ifdef WINGEN_COORD_EN
         chk("out_x", 160'(out_x), 160'(q[0].x));
         chk("out_y", 160'(out_y), 160'(q[0].y));
`endif
      end
      if (want_first && out_valid) begin
         want_first = 1'b0;
         chk("first_win_lane0", 160'(window[0]), 160'(72'h0C0B0A070605020100));
         t = window[0];
         s = 0;
         repeat (9) begin
            s += int'(t[7:0]);
            t = t >> 8;
         end
         chk("first_win_sum", 160'(s), 160'(54));
      end
   endtask

   task automatic step(input bit v, input bit sof, input bit ordy, output bit acc);
      int pr, pc;
      bit rdy;
      pr        = sof ? 0 : mr;
      pc        = sof ? 0 : mc;
      in_valid  = v;
      in_sof    = sof;
      out_ready = ordy;
      in_pix    = v ? {pix(1, pr, pc), pix(0, pr, pc)} : 16'hEEEE;
      #1;
      rdy = (q.size() == 0) || ordy;
      chk("in_ready", 160'(in_ready), 160'(rdy));
      acc = v && rdy;
      if (out_valid && ordy) begin
         dut_wins++;
         if (out_eol) dut_eols++;
      end
      @(posedge clk);
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
         if (pr >= 2 && pc >= 2) q.push_back(mk(pr, pc));
         if (pc == W - 1) begin
            mc = 0;
            mr = (pr == H - 1) ? 0 : pr + 1;
         end else begin
            mc = pc + 1;
            mr = pr;
         end
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic run(input int beats, input bit sof_first, input bit toggle, input int stall_len);
      int n = 0, cyc = 0, stall = stall_len;
      bit a, v, o;
      while (n < beats && cyc < beats * 4 + 40) begin
         v = toggle ? (cyc % 2 == 0) : 1'b1;
         o = 1'b1;
         if (stall > 0 && q.size() != 0) begin
            o = 1'b0;
            stall--;
         end
         step(v, sof_first && n == 0 && v, o, a);
         if (a) n++;
         cyc++;
      end
      chk("beats_accepted", 160'(n), 160'(beats));
   endtask

   task automatic frame(input string tag, input bit sof_first, input bit toggle, input int stall_len);
      bit a;
      dut_wins = 0;
      dut_eols = 0;
      run(W * H, sof_first, toggle, stall_len);
      step(1'b0, 1'b0, 1'b1, a);
      step(1'b0, 1'b0, 1'b1, a);
      chk({tag, "_windows"}, 160'(dut_wins), 160'(6));
      chk({tag, "_eols"}, 160'(dut_eols), 160'(2));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b0;
      in_pix    = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_out_sof", 160'(out_sof), 160'(0));
      chk("rst_out_eol", 160'(out_eol), 160'(0));
      chk("rst_window", 160'(window), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      reset = 1'b0;
      @(negedge clk);

      want_first = 1'b1;
      frame("plain", 1'b0, 1'b0, 0);
      frame("stall", 1'b0, 1'b0, 4);
      frame("toggle", 1'b0, 1'b1, 0);

      begin : sof_restart
         run(7, 1'b0, 1'b0, 0);
         frame("sof", 1'b1, 1'b0, 0);
      end

      begin : mid_reset
         run(13, 1'b0, 1'b0, 0);
         chk("pre_reset_valid", 160'(out_valid), 160'(1));
         out_ready = 1'b0;
         in_valid  = 1'b0;
         #2 reset = 1'b1;
         #1;
         chk("async_rst_valid", 160'(out_valid), 160'(0));
         chk("async_rst_sof", 160'(out_sof), 160'(0));
         chk("async_rst_window", 160'(window), 160'(0));
         q.delete();
         mr = 0;
         mc = 0;
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         frame("post_reset", 1'b0, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
